// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU opcodes and
// the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_BEQ = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational integer ALU: (a, b, op) -> (result, zero).
// Unknown opcodes give result 0 and zero 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SH_W = $clog2(WIDTH);

  // Shifts use the full unsigned B, so anything >= WIDTH clears the result.
  logic shift_oob;
  assign shift_oob = (b >= WIDTH'(WIDTH));

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    result = '0;
    zero   = 1'b0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = shift_oob ? '0 : (a << b[SH_W-1:0]);
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SRL: result = shift_oob ? '0 : (a >> b[SH_W-1:0]);
      ALU_SUB: result = a - b;
      ALU_XOR: result = a ^ b;
      ALU_BEQ: zero   = (a == b);
      ALU_BNE: zero   = (a != b);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration;
// one operation in flight: capture operands -> compute -> hold response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic             last_grant;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_code;
  logic             op_id;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // Grants are combinational in IDLE; on contention the requester that did
  // not win last time goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a      (op_a),
    .b      (op_b),
    .op     (op_code),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // NOTE: operand registers carry no reset; they are only read in EXEC, which is always entered through a grant that loads them.
  always_ff @(posedge clk) begin
    if (grant0 || grant1) begin
      op_a    <= grant1 ? req1_a  : req0_a;
      op_b    <= grant1 ? req1_b  : req0_b;
      op_code <= grant1 ? req1_op : req0_op;
      op_id   <= grant1;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            last_grant <= grant1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_id     <= op_id;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          // Response stays frozen until consumed; no grant in the consume cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_ONE;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero;
  logic [31:0] rsp_result;
  logic [15:0] op_count;

  logic        w4_req0_ready, w4_req1_ready, w4_rsp_valid, w4_rsp_id, w4_rsp_zero;
  logic [31:0] w4_rsp_result;
  logic [3:0]  w4_op_count;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .op_count(op_count)
  );

  alu_arbiter #(.WIDTH(32), .CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(w4_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(w4_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(w4_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w4_rsp_id), .rsp_result(w4_rsp_result),
    .rsp_zero(w4_rsp_zero), .op_count(w4_op_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU from the opcode table; returns {zero, result}.
  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] r;
    logic        z;
    r = 32'd0;
    z = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = (b >= 32) ? 32'd0 : (a << b);
      4'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: r = (b >= 32) ? 32'd0 : (a >> b);
      4'd6: r = a - b;
      4'd7: r = a ^ b;
      4'd8: z = (a == b);
      4'd9: z = (a != b);
      default: ;
    endcase
    return {z, r};
  endfunction

  // Transaction model: one operation in flight, response visible from
  // grant cycle + 2 until consumed.
  int          cyc = 0;
  bit          busy = 0;
  int          due = 0;
  bit          m_last = 1;
  int unsigned m_count = 0;
  logic [32:0] m_rsp;
  bit          m_id;
  logic        s_r0, s_r1;

  function automatic bit rsp_visible();
    return busy && (cyc >= due);
  endfunction

  task automatic cycle();
    bit e0, e1;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!reset && !busy) begin
      if (req0_valid && req1_valid) begin
        if (m_last) e0 = 1'b1; else e1 = 1'b1;
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("w4_req0_ready", w4_req0_ready, e0);
    check("w4_req1_ready", w4_req1_ready, e1);
    @(posedge clk);
    if (reset) begin
      busy    = 0;
      m_last  = 1;
      m_count = 0;
    end else if (e0 || e1) begin
      busy   = 1;
      due    = cyc + 2;
      m_id   = e1;
      m_last = e1;
      m_rsp  = e1 ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
    end else if (rsp_visible() && rsp_ready) begin
      busy = 0;
      m_count++;
    end
    cyc++;
    @(negedge clk);
    check("rsp_valid", rsp_valid, rsp_visible());
    check("w4_rsp_valid", w4_rsp_valid, rsp_visible());
    check("op_count", op_count, m_count % 65536);
    check("w4_op_count", w4_op_count, m_count % 16);
    if (rsp_visible()) begin
      check("rsp_result", rsp_result, m_rsp[31:0]);
      check("rsp_zero", rsp_zero, m_rsp[32]);
      check("rsp_id", rsp_id, m_id);
      check("w4_rsp_result", w4_rsp_result, m_rsp[31:0]);
      check("w4_rsp_zero", w4_rsp_zero, m_rsp[32]);
      check("w4_rsp_id", w4_rsp_id, m_id);
    end
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  // Solo operation from an idle arbiter: checks grant latency and result.
  task automatic do_op(input string tag, input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] er, input logic ez);
    int gk, rk;
    gk = -1;
    rk = -1;
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    for (int k = 0; k < 8 && rk < 0; k++) begin
      cycle();
      if (s_r0 || s_r1) begin
        gk = k;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      if (rsp_valid) begin
        rk = k;
        check({tag, "_result"}, rsp_result, er);
        check({tag, "_zero"}, rsp_zero, ez);
        check({tag, "_id"}, rsp_id, id);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_grant_cycle"}, gk, 0);
    check({tag, "_latency"}, rk + 1 - gk, 2);
    cycle();
  endtask

  task automatic rand_req(output logic [31:0] a, output logic [31:0] b, output logic [3:0] op);
    a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    int          grants[$];
    logic [31:0] results[$];
    logic        ids[$];

    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    cycle();
    cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_zero", rsp_zero, 1'b0);
    check("rst_op_count", op_count, 16'd0);

    // 1: single ADD
    do_op("t1_add", 1'b0, 32'hFFFF_FFF1, 32'd5, 4'b0000, 32'hFFFF_FFF6, 1'b0);
    check("t1_op_count", op_count, 16'd1);

    // 2: contention from reset, four back-to-back ops
    do_reset();
    rsp_ready = 1'b1;
    req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 4'b0001;
    req1_a = 32'hF0; req1_b = 32'h3C; req1_op = 4'b0010;
    for (int k = 0; k < 40 && grants.size() < 4; k++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      cycle();
      if (s_r0) grants.push_back(0);
      if (s_r1) grants.push_back(1);
      if (rsp_valid) begin results.push_back(rsp_result); ids.push_back(rsp_id); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (rsp_valid) begin results.push_back(rsp_result); ids.push_back(rsp_id); end
    end
    check("t2_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) check("t2_grant_order", grants[i], i % 2);
    check("t2_rsp_count", results.size(), 4);
    for (int i = 0; i < results.size(); i++) begin
      check("t2_rsp_result", results[i], (i % 2 == 0) ? 32'h30 : 32'hFC);
      check("t2_rsp_id", ids[i], i % 2);
    end
    drain();

    // 3: backpressure on SUB 5-7
    c0 = int'(op_count);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'b0110;
    cycle();
    check("t3_grant", s_r0, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h12; req1_b = 32'h34; req1_op = 4'b0000;
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t3_hold_valid", rsp_valid, 1'b1);
      check("t3_hold_result", rsp_result, 32'hFFFF_FFFE);
      check("t3_no_ready", s_r1, 1'b0);
      check("t3_count_held", op_count, 16'(c0));
    end
    rsp_ready = 1'b1;
    cycle();
    check("t3_no_grant_on_consume", s_r1, 1'b0);
    check("t3_count_inc", op_count, 16'(c0 + 1));
    drain();

    // 4: opcode corner cases
    do_op("t4_slt", 1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0100, 32'd1, 1'b0);
    do_op("t4_srl", 1'b1, 32'h8000_0000, 32'd31, 4'b0101, 32'd1, 1'b0);
    do_op("t4_sll", 1'b0, 32'd1, 32'd32, 4'b0011, 32'd0, 1'b0);
    do_op("t4_beq", 1'b1, 32'd9, 32'd9, 4'b1000, 32'd0, 1'b1);
    do_op("t4_bne", 1'b0, 32'd9, 32'd9, 4'b1001, 32'd0, 1'b0);
    do_op("t4_bad", 1'b1, 32'h55, 32'h55, 4'b1010, 32'd0, 1'b0);

    // 5: reset while in EXEC
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'b0000;
    cycle();
    check("t5_grant", s_r0, 1'b1);
    req0_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_op_count", op_count, 16'd0);
    do_op("t5_xor", 1'b1, 32'hFF, 32'h0F, 4'b0111, 32'hF0, 1'b0);

    // 6: counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 16; i++)
      do_op("t6_add", 1'(i % 2), 32'(i), 32'(i), 4'b0000, 32'(2 * i), 1'b0);
    check("t6_w4_wrap", w4_op_count, 4'd0);
    check("t6_op_count", op_count, 16'd16);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      rsp_ready = $urandom_range(0, 1) == 1;
      cycle();
      if (s_r0) begin
        rand_req(req0_a, req0_b, req0_op);
        req0_valid = $urandom_range(0, 1) == 1;
      end else if (req0_valid && $urandom_range(0, 15) == 0) begin
        req0_valid = 1'b0;
      end else if (!req0_valid && $urandom_range(0, 2) == 0) begin
        rand_req(req0_a, req0_b, req0_op);
        req0_valid = 1'b1;
      end
      if (s_r1) begin
        rand_req(req1_a, req1_b, req1_op);
        req1_valid = $urandom_range(0, 1) == 1;
      end else if (req1_valid && $urandom_range(0, 15) == 0) begin
        req1_valid = 1'b0;
      end else if (!req1_valid && $urandom_range(0, 2) == 0) begin
        rand_req(req1_a, req1_b, req1_op);
        req1_valid = 1'b1;
      end
    end
    reset = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
